// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init FSM states and default 100 MHz timing.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam int unsigned DEF_T_POWERUP = 20000;
    localparam int unsigned DEF_T_RP      = 2;
    localparam int unsigned DEF_T_RFC     = 7;
    localparam int unsigned DEF_T_MRD     = 2;
    localparam int unsigned DEF_AR_NUM    = 2;

    // Holds AR_NUM up to 15.
    localparam int unsigned AR_CNT_W = 4;

    // Gray-like walk: neighbouring states differ in one bit.
    typedef enum logic [3:0] {
        StIdle  = 4'b0000,
        StPre   = 4'b0001,
        StTrp   = 4'b0011,
        StAr    = 4'b0010,
        StTrfc  = 4'b0110,
        StMrs   = 4'b0111,
        StTmrd  = 4'b0101,
        StEmrs  = 4'b0100,
        StTemrd = 4'b1100,
        StEnd   = 4'b1101
    } init_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The command cycle and the cycle that loads the counter both count toward T_x.
    function automatic int unsigned wait_load(input int unsigned t);
        return (t >= 2) ? t - 2 : 0;
    endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter; done_o is high while the count is zero.
module sdram_delay_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_ext.sv
// SDRAM power-up init sequencer with re-init request; define SDRAM_EMRS_EN to also
// program the extended mode register of mobile parts.
module sdram_init_ext
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_RP      = DEF_T_RP,
    parameter int unsigned T_RFC     = DEF_T_RFC,
    parameter int unsigned T_MRD     = DEF_T_MRD,
    parameter int unsigned AR_NUM    = DEF_AR_NUM,
    parameter logic [31:0] MR_VAL    = 32'h037,
    parameter logic [31:0] EMR_VAL   = 32'h000
) (
    input  logic              init_clk,
    input  logic              init_rst,
    input  logic              init_req,
    output logic              init_end,
    output logic              init_busy,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_bank,
    output logic [ADDR_W-1:0] init_addr
);

    localparam int unsigned MaxT = max_u(max_u(T_POWERUP, T_RP), max_u(T_RFC, T_MRD));
    localparam int unsigned CntW = (MaxT < 2) ? 1 : $clog2(MaxT + 1);

    localparam logic [CntW-1:0]     PwrLoad = CntW'(T_POWERUP - 1);
    localparam logic [CntW-1:0]     RpLoad  = CntW'(wait_load(T_RP));
    localparam logic [CntW-1:0]     RfcLoad = CntW'(wait_load(T_RFC));
    localparam logic [CntW-1:0]     MrdLoad = CntW'(wait_load(T_MRD));
    localparam logic [AR_CNT_W-1:0] ArLim   = AR_CNT_W'(AR_NUM);

    init_state_e         state_q, state_d, after_mrd;
    logic [AR_CNT_W-1:0] ar_q, ar_d, ar_inc;
    logic                pwrup_q, pwrup_d;
    logic                load;
    logic [CntW-1:0]     load_val;
    logic                cnt_done;

    logic [3:0]        cmd_d;
    logic [BA_W-1:0]   bank_d;
    logic [ADDR_W-1:0] addr_d;

    sdram_delay_cnt #(
        .Width (CntW)
    ) u_delay_cnt (
        .clk_i      (init_clk),
        .rst_i      (init_rst),
        .load_i     (load),
        .load_val_i (load_val),
        .done_o     (cnt_done)
    );

`ifdef SDRAM_EMRS_EN
    assign after_mrd = StEmrs;
`else
    assign after_mrd = StEnd;
    logic unused_emr;
    assign unused_emr = ^EMR_VAL;
`endif

    assign ar_inc = ar_q + AR_CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        pwrup_d  = pwrup_q;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            StIdle: begin
                // First non-reset cycle arms the power-up wait.
                if (!pwrup_q) begin
                    load     = 1'b1;
                    load_val = PwrLoad;
                    pwrup_d  = 1'b1;
                end else if (cnt_done) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                if (T_RP > 1) begin
                    state_d  = StTrp;
                    load     = 1'b1;
                    load_val = RpLoad;
                end else begin
                    state_d = StAr;
                end
            end
            StTrp: if (cnt_done) state_d = StAr;
            StAr: begin
                ar_d = ar_inc;
                if (T_RFC > 1) begin
                    state_d  = StTrfc;
                    load     = 1'b1;
                    load_val = RfcLoad;
                end else if (ar_inc < ArLim) begin
                    state_d = StAr;
                end else begin
                    ar_d    = '0;
                    state_d = StMrs;
                end
            end
            StTrfc: begin
                if (cnt_done) begin
                    if (ar_q < ArLim) begin
                        state_d = StAr;
                    end else begin
                        ar_d    = '0;
                        state_d = StMrs;
                    end
                end
            end
            StMrs: begin
                if (T_MRD > 1) begin
                    state_d  = StTmrd;
                    load     = 1'b1;
                    load_val = MrdLoad;
                end else begin
                    state_d = after_mrd;
                end
            end
            StTmrd: if (cnt_done) state_d = after_mrd;
`ifdef SDRAM_EMRS_EN
            StEmrs: begin
                if (T_MRD > 1) begin
                    state_d  = StTemrd;
                    load     = 1'b1;
                    load_val = MrdLoad;
                end else begin
                    state_d = StEnd;
                end
            end
            StTemrd: if (cnt_done) state_d = StEnd;
`endif
            StEnd: if (init_req) state_d = StPre;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = '0;
        addr_d = '0;
        unique case (state_d)
            StPre: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            StAr:  cmd_d = CMD_AR;
            StMrs: begin
                cmd_d  = CMD_MRS;
                addr_d = ADDR_W'(MR_VAL);
            end
`ifdef SDRAM_EMRS_EN
            StEmrs: begin
                cmd_d  = CMD_MRS;
                bank_d = BA_W'(2'b10);
                addr_d = ADDR_W'(EMR_VAL);
            end
`endif
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge init_clk) begin
        if (init_rst) begin
            state_q   <= StIdle;
            ar_q      <= '0;
            pwrup_q   <= 1'b0;
            init_cmd  <= CMD_NOP;
            init_bank <= '0;
            init_addr <= '0;
            init_end  <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            ar_q      <= ar_d;
            pwrup_q   <= pwrup_d;
            init_cmd  <= cmd_d;
            init_bank <= bank_d;
            init_addr <= addr_d;
            init_end  <= (state_d == StEnd);
            init_busy <= (state_d != StEnd);
        end
    end

endmodule

// File: tb/tb_sdram_init_ext.sv
// Directed bench for sdram_init_ext: three parameterisations exercised one after another.
module tb_sdram_init_ext;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

`ifdef SDRAM_EMRS_EN
    localparam int EmrsExtra = 1;
`else
    localparam int EmrsExtra = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic a_rst = 1'b1, a_req = 1'b0, a_end, a_busy;
    logic [3:0] a_cmd; logic [1:0] a_bank; logic [12:0] a_addr;
    logic b_rst = 1'b1, b_req = 1'b0, b_end, b_busy;
    logic [3:0] b_cmd; logic [1:0] b_bank; logic [12:0] b_addr;
    logic c_rst = 1'b1, c_req = 1'b0, c_end, c_busy;
    logic [3:0] c_cmd; logic [1:0] c_bank; logic [12:0] c_addr;

    sdram_init_ext #(.T_POWERUP(100)) dut_a (
        .init_clk (clk), .init_rst (a_rst), .init_req (a_req), .init_end (a_end),
        .init_busy (a_busy), .init_cmd (a_cmd), .init_bank (a_bank), .init_addr (a_addr)
    );

    sdram_init_ext #(.T_POWERUP(10), .AR_NUM(8), .T_RFC(7), .EMR_VAL(32'h020)) dut_b (
        .init_clk (clk), .init_rst (b_rst), .init_req (b_req), .init_end (b_end),
        .init_busy (b_busy), .init_cmd (b_cmd), .init_bank (b_bank), .init_addr (b_addr)
    );

    sdram_init_ext #(.T_POWERUP(5), .T_RP(1), .T_RFC(1), .T_MRD(1)) dut_c (
        .init_clk (clk), .init_rst (c_rst), .init_req (c_req), .init_end (c_end),
        .init_busy (c_busy), .init_cmd (c_cmd), .init_bank (c_bank), .init_addr (c_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] o_cmd, input logic [1:0] o_bank,
                           input logic [12:0] o_addr, input logic o_end, input logic o_busy,
                           input logic [3:0] e_cmd, input logic [1:0] e_bank,
                           input logic [12:0] e_addr, input logic e_end);
        chk({tag, "_cmd"}, 32'(o_cmd), 32'(e_cmd));
        chk({tag, "_bank"}, 32'(o_bank), 32'(e_bank));
        chk({tag, "_addr"}, 32'(o_addr), 32'(e_addr));
        chk({tag, "_end"}, 32'(o_end), 32'(e_end));
        chk({tag, "_busy"}, 32'(o_busy), 32'(!e_end));
    endtask

    // DUT A from its PRECHARGE cycle (k=0): AR at 2 and 9, MRS at 16, END at 18 (+2 with EMRS).
    task automatic seq_a(input string tag, input int req_at);
        int end_off;
        logic [3:0] e_cmd; logic [1:0] e_bank; logic [12:0] e_addr;
        end_off = 18 + 2 * EmrsExtra;
        for (int k = 0; k <= end_off + 2; k++) begin
            tick();
            e_cmd = NOP; e_bank = 2'd0; e_addr = 13'h000;
            if (k == 0) begin e_cmd = PRE; e_addr = 13'h400; end
            if (k == 2 || k == 9) e_cmd = AR;
            if (k == 16) begin e_cmd = MRS; e_addr = 13'h037; end
            if (EmrsExtra == 1 && k == 18) begin e_cmd = MRS; e_bank = 2'b10; end
            chk_all($sformatf("%s_k%0d", tag, k), a_cmd, a_bank, a_addr, a_end, a_busy,
                    e_cmd, e_bank, e_addr, k >= end_off);
            a_req = (k == req_at);
        end
    endtask

    initial begin
        int ar_seen;
        int end_b;
        int end_c;
        logic [3:0] e_cmd; logic [1:0] e_bank; logic [12:0] e_addr;

        repeat (3) tick();
        chk_all("a_reset", a_cmd, a_bank, a_addr, a_end, a_busy, NOP, 2'd0, 13'h000, 1'b0);
        chk_all("c_reset", c_cmd, c_bank, c_addr, c_end, c_busy, NOP, 2'd0, 13'h000, 1'b0);

        // Power-up: NOP for cycles 0..99, then the PRE..END schedule.
        a_rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk($sformatf("a_pwrup_c%0d_cmd", c), 32'(a_cmd), 32'(NOP));
            if (c == 99) chk("a_pwrup_busy", 32'(a_busy), 32'd1);
        end
        seq_a("a_init", -1);

        // Re-init from END, with a second request mid-sequence that must be ignored.
        a_req = 1'b1;
        seq_a("a_reinit", 5);

        // Reset during TRFC of the first AR, then the full power-up wait again.
        a_req = 1'b1;
        tick();
        chk("a_rr_pre_cmd", 32'(a_cmd), 32'(PRE));
        a_req = 1'b0;
        tick();
        tick();
        chk("a_rr_ar_cmd", 32'(a_cmd), 32'(AR));
        tick();
        a_rst = 1'b1;
        tick();
        chk_all("a_midrst", a_cmd, a_bank, a_addr, a_end, a_busy, NOP, 2'd0, 13'h000, 1'b0);
        a_rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk($sformatf("a_rewait_c%0d_cmd", c), 32'(a_cmd), 32'(NOP));
        end
        tick();
        chk_all("a_rewait_pre", a_cmd, a_bank, a_addr, a_end, a_busy, PRE, 2'd0, 13'h400, 1'b0);

        // Refresh count: PRE at 10, AR at 12 + 7n for n=0..7, MRS at 68.
        b_rst   = 1'b0;
        ar_seen = 0;
        end_b   = 70 + 2 * EmrsExtra;
        for (int c = 0; c <= end_b + 2; c++) begin
            tick();
            e_cmd = NOP; e_bank = 2'd0; e_addr = 13'h000;
            if (c == 10) begin e_cmd = PRE; e_addr = 13'h400; end
            if (c >= 12 && c <= 61 && (c - 12) % 7 == 0) e_cmd = AR;
            if (c == 68) begin e_cmd = MRS; e_addr = 13'h037; end
            if (EmrsExtra == 1 && c == 70) begin e_cmd = MRS; e_bank = 2'b10; e_addr = 13'h020; end
            if (b_cmd === AR) ar_seen++;
            chk_all($sformatf("b_c%0d", c), b_cmd, b_bank, b_addr, b_end, b_busy,
                    e_cmd, e_bank, e_addr, c >= end_b);
        end
        chk("b_ar_count", 32'(ar_seen), 32'd8);

        // Minimum timing: PRE, AR, AR, MRS on consecutive cycles from cycle 5.
        c_rst = 1'b0;
        end_c = 9 + EmrsExtra;
        for (int c = 0; c <= end_c + 1; c++) begin
            tick();
            e_cmd = NOP; e_bank = 2'd0; e_addr = 13'h000;
            if (c == 5) begin e_cmd = PRE; e_addr = 13'h400; end
            if (c == 6 || c == 7) e_cmd = AR;
            if (c == 8) begin e_cmd = MRS; e_addr = 13'h037; end
            if (EmrsExtra == 1 && c == 9) begin e_cmd = MRS; e_bank = 2'b10; end
            chk_all($sformatf("c_c%0d", c), c_cmd, c_bank, c_addr, c_end, c_busy,
                    e_cmd, e_bank, e_addr, c >= end_c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
